// File: rtl/vga_framebuffer.sv
// RGB332 160x120 framebuffer, scaled 4x onto a 640x480 VGA scan, with an MCU write port.
// Define VGA_FB_CLEAR_EN to build the hardware clear engine that fills the whole buffer.
module vga_framebuffer #(
  parameter int FB_W     = 160,
  parameter int FB_H     = 120,
  parameter int FB_DEPTH = 19200
) (
  input  logic        clk_25M,
  input  logic        reset,
  input  logic [9:0]  x_pos,
  input  logic [9:0]  y_pos,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue,
  input  logic        wr_en,
  input  logic [14:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  input  logic        clr_req,
  input  logic [7:0]  clr_color,
  output logic        clr_busy
);

  localparam logic [9:0]  VIS_W     = 10'(FB_W * 4);
  localparam logic [9:0]  VIS_H     = 10'(FB_H * 4);
  localparam logic [14:0] DEPTH     = 15'(FB_DEPTH);
  localparam logic [14:0] LAST_ADDR = 15'(FB_DEPTH - 1);

  logic [7:0]  mem [0:FB_DEPTH-1];
  logic [7:0]  ram_q;
  logic        vis_q;

  logic [9:0]  xa;
  logic [14:0] row;
  logic [14:0] col;
  logic [14:0] rd_addr;
  logic        vis_a;

  logic        ram_we;
  logic [14:0] ram_waddr;
  logic [7:0]  ram_wdata;

  logic        fill_active;
  logic [14:0] fill_addr;
  logic [7:0]  fill_color;

  // Fetch one column ahead so the registered RAM output lines up with x_pos.
  assign xa      = x_pos + 10'd1;
  assign row     = {7'd0, y_pos[9:2]};
  assign col     = {7'd0, xa[9:2]};
  assign rd_addr = (row << 7) + (row << 5) + col;
  assign vis_a   = (xa < VIS_W) && (y_pos < VIS_H);

  always_ff @(posedge clk_25M) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
    ram_q <= mem[rd_addr];
  end

  always_ff @(posedge clk_25M) begin
    if (reset) begin
      vis_q <= 1'b0;
    end else begin
      vis_q <= vis_a;
    end
  end

  assign {red, green, blue} = vis_q ? ram_q : 8'd0;

`ifdef VGA_FB_CLEAR_EN
  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t      state, state_next;
  logic [14:0] fill_addr_next;
  logic [7:0]  fill_color_next;

  always_ff @(posedge clk_25M) begin
    if (reset) begin
      state      <= IDLE;
      fill_addr  <= 15'd0;
      fill_color <= 8'd0;
    end else begin
      state      <= state_next;
      fill_addr  <= fill_addr_next;
      fill_color <= fill_color_next;
    end
  end

  always_comb begin
    state_next      = state;
    fill_addr_next  = fill_addr;
    fill_color_next = fill_color;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_next      = FILL;
          fill_addr_next  = 15'd0;
          fill_color_next = clr_color;
        end
      end
      FILL: begin
        if (fill_addr == LAST_ADDR) begin
          state_next     = IDLE;
          fill_addr_next = 15'd0;
        end else begin
          fill_addr_next = fill_addr + 15'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign fill_active = (state == FILL);
  assign clr_busy    = fill_active;
  assign wr_ready    = !clr_busy;
`else
  logic unused_clr;

  assign unused_clr  = ^{clr_req, clr_color};
  assign fill_active = 1'b0;
  assign fill_addr   = 15'd0;
  assign fill_color  = 8'd0;
  assign clr_busy    = 1'b0;
  assign wr_ready    = 1'b1;
`endif

  // The fill engine owns the write port while active; a reset cycle writes nothing.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    if (!reset) begin
      if (fill_active) begin
        ram_we    = 1'b1;
        ram_waddr = fill_addr;
        ram_wdata = fill_color;
      end else if (wr_en && wr_ready && (wr_addr < DEPTH)) begin
        ram_we = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_framebuffer.sv
// Directed self-checking bench for vga_framebuffer; clear-engine checks follow VGA_FB_CLEAR_EN.
module tb_vga_framebuffer;

  logic        clk_25M;
  logic        reset;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic [2:0]  red;
  logic [2:0]  green;
  logic [1:0]  blue;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        clr_req;
  logic [7:0]  clr_color;
  logic        clr_busy;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] expected;
  } vec_t;

  vec_t vecs [16];

  vga_framebuffer dut (
    .clk_25M  (clk_25M),
    .reset    (reset),
    .x_pos    (x_pos),
    .y_pos    (y_pos),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .clr_req  (clr_req),
    .clr_color(clr_color),
    .clr_busy (clr_busy)
  );

  initial begin
    clk_25M = 1'b0;
    forever #20 clk_25M = ~clk_25M;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic writePixel(input logic [14:0] a, input logic [7:0] d);
    @(negedge clk_25M);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk_25M);
    wr_en = 1'b0;
  endtask

  // Present the column before x for one cycle, then x; the colour for x is then on the outputs.
  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y);
    @(negedge clk_25M);
    x_pos = x - 10'd1;
    y_pos = y;
    @(negedge clk_25M);
    x_pos = x;
  endtask

  function automatic logic [7:0] rgb();
    return {red, green, blue};
  endfunction

`ifdef VGA_FB_CLEAR_EN
  // Walks every framebuffer pixel once and counts those not equal to c.
  task automatic scanAll(input logic [7:0] c, output int bad);
    bad = 0;
    for (int r = 0; r < 120; r++) begin
      @(negedge clk_25M);
      y_pos = 10'(r * 4);
      x_pos = 10'd1023;
      for (int k = 0; k < 160; k++) begin
        @(negedge clk_25M);
        x_pos = 10'(k * 4 + 3);
        if (rgb() !== c) bad++;
      end
    end
  endtask
`endif

  initial begin
    vecs[0]  = '{10'd0,    10'd0,   8'hE0};
    vecs[1]  = '{10'd3,    10'd0,   8'hE0};
    vecs[2]  = '{10'd4,    10'd0,   8'h1C};
    vecs[3]  = '{10'd7,    10'd0,   8'h1C};
    vecs[4]  = '{10'd639,  10'd0,   8'hAA};
    vecs[5]  = '{10'd636,  10'd3,   8'hAA};
    vecs[6]  = '{10'd640,  10'd0,   8'h00};
    vecs[7]  = '{10'd1022, 10'd0,   8'h00};
    vecs[8]  = '{10'd1023, 10'd0,   8'h00};
    vecs[9]  = '{10'd2,    10'd5,   8'h55};
    vecs[10] = '{10'd0,    10'd479, 8'h77};
    vecs[11] = '{10'd0,    10'd480, 8'h00};
    vecs[12] = '{10'd639,  10'd479, 8'h3C};
    vecs[13] = '{10'd636,  10'd476, 8'h3C};
    vecs[14] = '{10'd639,  10'd480, 8'h00};
    vecs[15] = '{10'd0,    10'd3,   8'hE0};

    reset     = 1'b1;
    x_pos     = 10'd0;
    y_pos     = 10'd0;
    wr_en     = 1'b0;
    wr_addr   = 15'd0;
    wr_data   = 8'd0;
    clr_req   = 1'b0;
    clr_color = 8'd0;
    repeat (3) @(negedge clk_25M);
    checkOutput("reset_rgb", rgb(), 8'h00);
    checkOutput("reset_wr_ready", wr_ready, 1'b1);
    checkOutput("reset_clr_busy", clr_busy, 1'b0);
    reset = 1'b0;

    writePixel(15'd0,     8'hE0);
    writePixel(15'd1,     8'h1C);
    writePixel(15'd2,     8'h11);
    writePixel(15'd159,   8'hAA);
    writePixel(15'd160,   8'h55);
    writePixel(15'd19040, 8'h77);
    writePixel(15'd19199, 8'h3C);

    // Continuous scan across the row start, checked every cycle.
    @(negedge clk_25M);
    y_pos = 10'd0;
    x_pos = 10'd1023;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_25M);
      x_pos = 10'(i);
      checkOutput($sformatf("fetch_x%0d", i), rgb(), (i < 4) ? 8'hE0 : 8'h1C);
    end

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].x, vecs[i].y);
      checkOutput($sformatf("vec%0d_x%0d_y%0d", i, vecs[i].x, vecs[i].y), rgb(), vecs[i].expected);
    end

    // A read and a write to the same address in one cycle returns the old value.
    @(negedge clk_25M);
    x_pos   = 10'd7;
    y_pos   = 10'd0;
    wr_en   = 1'b1;
    wr_addr = 15'd2;
    wr_data = 8'h22;
    @(negedge clk_25M);
    wr_en = 1'b0;
    x_pos = 10'd8;
    checkOutput("same_cycle_old", rgb(), 8'h11);
    applyStimulus(10'd8, 10'd0);
    checkOutput("write_then_read", rgb(), 8'h22);

    writePixel(15'd19200, 8'hFF);
    applyStimulus(10'd638, 10'd477);
    checkOutput("oob_dropped", rgb(), 8'h3C);
    writePixel(15'd19199, 8'h81);
    applyStimulus(10'd637, 10'd478);
    checkOutput("last_addr_write", rgb(), 8'h81);

`ifdef VGA_FB_CLEAR_EN
    begin
      int busy_cycles;
      int bad;
      @(negedge clk_25M);
      clr_req   = 1'b1;
      clr_color = 8'h03;
      wr_en     = 1'b1;
      wr_addr   = 15'd5;
      wr_data   = 8'h99;
      x_pos     = 10'd19;
      y_pos     = 10'd0;
      @(negedge clk_25M);
      clr_req = 1'b0;
      wr_addr = 15'd0;
      wr_data = 8'hEE;
      checkOutput("clr_busy_rise", clr_busy, 1'b1);
      checkOutput("wr_ready_low", wr_ready, 1'b0);
      busy_cycles = 0;
      while (clr_busy === 1'b1 && busy_cycles < 20000) begin
        busy_cycles++;
        @(negedge clk_25M);
        if (busy_cycles == 1) checkOutput("simul_write_landed", rgb(), 8'h99);
      end
      wr_en = 1'b0;
      checkOutput("clr_busy_cycles", busy_cycles, 19200);
      checkOutput("wr_ready_after", wr_ready, 1'b1);
      scanAll(8'h03, bad);
      checkOutput("clear_all_pixels_bad", bad, 0);

      @(negedge clk_25M);
      clr_req   = 1'b1;
      clr_color = 8'h5A;
      @(negedge clk_25M);
      clr_req = 1'b0;
      repeat (100) @(negedge clk_25M);
      x_pos  = 10'd1023;
      y_pos  = 10'd0;
      reset  = 1'b1;
      @(negedge clk_25M);
      checkOutput("midfill_clr_busy", clr_busy, 1'b0);
      checkOutput("midfill_wr_ready", wr_ready, 1'b1);
      x_pos = 10'd0;
      @(negedge clk_25M);
      checkOutput("midfill_rgb", rgb(), 8'h00);
      reset = 1'b0;
      applyStimulus(10'd396, 10'd0);
      checkOutput("midfill_addr99", rgb(), 8'h5A);
      applyStimulus(10'd400, 10'd0);
      checkOutput("midfill_addr100", rgb(), 8'h03);
      applyStimulus(10'd637, 10'd478);
      checkOutput("midfill_addr19199", rgb(), 8'h03);
    end
`else
    @(negedge clk_25M);
    clr_req   = 1'b1;
    clr_color = 8'h03;
    @(negedge clk_25M);
    clr_req = 1'b0;
    checkOutput("noclr_busy", clr_busy, 1'b0);
    checkOutput("noclr_wr_ready", wr_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_25M);
      wr_en   = 1'b1;
      wr_addr = 15'(3 + i);
      wr_data = 8'(8'h42 + i);
      checkOutput($sformatf("noclr_ready_%0d", i), wr_ready, 1'b1);
    end
    @(negedge clk_25M);
    wr_en = 1'b0;
    checkOutput("noclr_busy_late", clr_busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(10'(12 + 4 * i), 10'd0);
      checkOutput($sformatf("noclr_b2b_addr%0d", 3 + i), rgb(), 8'(8'h42 + i));
    end
    applyStimulus(10'd0, 10'd0);
    checkOutput("noclr_ram_unchanged", rgb(), 8'hE0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/vga_framebuffer.md
# vga_framebuffer

RGB332 pixel source that feeds the VGA driver's colour inputs. Holds a 160×120 framebuffer scaled 4× to 640×480. Returns the colour for the driver's `x_pos`/`y_pos` in the same cycle those coordinates are presented. Also provides an MCU write port and an optional hardware clear engine.

## Interface
- `FB_W`, 160: framebuffer width in pixels.
- `FB_H`, 120: framebuffer height in pixels.
- `FB_DEPTH`, 19200: number of bytes, equal to `FB_W*FB_H`.

Ports (one clock; reset is synchronous and active-high):
- `clk_25M` input 1: pixel clock, shared with the VGA driver.
- `reset` input 1: synchronous, active-high reset.
- `x_pos` input 10: next output column from the driver. 0..639 is visible; other values are blanking, wrapping mod 1024.
- `y_pos` input 10: current output row from the driver. 0..479 is visible.
- `red` output 3: connects to the driver's `redIn`.
- `green` output 3: connects to the driver's `greenIn`.
- `blue` output 2: connects to the driver's `blueIn`.
- `wr_en` input 1: MCU pixel write strobe.
- `wr_addr` input 15: linear pixel address, `y*160 + x`.
- `wr_data` input 8: RGB332 pixel, laid out as {R[2:0], G[2:0], B[1:0]}.
- `wr_ready` output 1: write port can accept; high when no clear is running.
- `clr_req` input 1: single-cycle pulse that starts a fill of the framebuffer.
- `clr_color` input 8: RGB332 fill value, sampled when `clr_req` is accepted.
- `clr_busy` output 1: high while a fill is in progress.

## Operation
- **Storage:** simple dual-port RAM, 19200×8. The read port is owned by video; the write port is shared by the MCU and the clear engine.
- **Read-ahead:** each cycle the block computes a look-ahead column `xa = (x_pos + 1) mod 1024`, using 10-bit wrap.
  - Address is `(y_pos>>2)*160 + (xa>>2)`.
  - The ×160 is implemented as `(r<<7)+(r<<5)`, 15-bit result.
  - `vis_a = (xa < 640) && (y_pos < 480)`.
  - The RAM performs a synchronous read. `vis_a` is delayed one cycle alongside the read to form `vis_q`.
- **Output:** `{red,green,blue} = vis_q ? ram_q : 0`.
  - Because of the read-ahead, the colour matches the `x_pos` presented in the same cycle.
- **MCU write:** accepted when `wr_en && wr_ready`; the RAM is written that cycle.
  - `wr_addr >= 19200` is silently dropped.
  - `wr_en` while `wr_ready=0` is dropped. The MCU must hold `wr_en` until it sees ready.
- **Clear FSM:**
  - IDLE: `clr_req` → FILL. On entry, latch `clr_color` and set `addr=0`.
  - FILL: write the latched colour to `addr` and increment. After writing `addr=19199`, return to IDLE.
  - Total duration is 19200 cycles.
  - `clr_req` during FILL is ignored.
- **Simultaneous `wr_en` and `clr_req` in IDLE:** the MCU write completes in that cycle. FILL starts the next cycle and overwrites it.
- **Writes during visible scan** are permitted; tearing is acceptable.
- **Reset:**
  - `red`, `green`, `blue` = 0.
  - `vis_q` = 0.
  - `clr_busy` = 0, `wr_ready` = 1, FSM = IDLE, fill address = 0.
  - RAM contents are not cleared.
- **Reset mid-FILL:** the fill aborts immediately, leaving the RAM partially filled, and the FSM returns to IDLE.

## Timing
- Video path latency is 1 cycle from the look-ahead coordinate. Measured against the `x_pos` of the same cycle, it is effectively 0.
- At the end of a row: x_pos 639 → 640. Look-ahead at 639 gives 640, which is not visible, so blanking starts exactly after column 639.
- Look-ahead at `x_pos=1023` gives 0, so column 0 of the row is prefetched during the last blanking cycle.
- Write-to-display latency: a write accepted at cycle t is visible on a read issued at cycle t+1 or later. Same-cycle read/write of one address returns old data.
- `clr_busy` rises the cycle after `clr_req` and falls the cycle after the write to address 19199.
- `wr_ready` equals `!clr_busy` combinationally from the registered state.

## Configuration
- `VGA_FB_CLEAR_EN` defined: the clear FSM is built exactly as described above.
- `VGA_FB_CLEAR_EN` undefined:
  - No FSM is built.
  - `clr_req` and `clr_color` are ignored.
  - `clr_busy` is tied to 0 and `wr_ready` is tied to 1.
  - The write port is MCU-only.

## Test plan
- **Basic pixel fetch:** write 0xE0 to address 0 and 0x1C to address 1. Drive `x_pos` 1023→0..7 with `y_pos=0`. Required: output 0xE0 for x=0..3, then 0x1C for x=4..7, aligned to the same cycle as `x_pos`.
- **Blanking:**
  - x_pos=639 returns the stored value; x_pos 640..1022 returns 0.
  - y_pos=480 returns 0 for every x.
  - y_pos=479 reads row 119.
- **Address bound:** write to address 19200 with data 0xFF is dropped; address 19199 (x=636..639, y=476..479) keeps its prior value. A write to 19199 is honoured.
- **Clear (`VGA_FB_CLEAR_EN`):**
  - Pulse `clr_req` with `clr_color=0x03`. Required: `clr_busy` high for exactly 19200 cycles; `wr_en` ignored throughout; all pixels then read 0x03.
  - `clr_req` with simultaneous `wr_en`: the write lands and is then overwritten.
- **Reset mid-FILL:** assert reset at fill address 100. Required: `clr_busy=0` and `wr_ready=1` next cycle, outputs 0; addresses ≥100 retain their old contents.
- **Clear compiled out:** `clr_req` pulse leaves `clr_busy=0` and RAM unchanged; MCU writes are accepted every cycle.
